riscv_wb_scoreboard: RTL and testbench

Self-checking writeback scoreboard for the pipelined RISC-V core bench. Replaces hand-timed `wb_e/wb_a/wb_d` checks and the hard-wired end-of-program PC loop. It holds an ordered queue of expected register writebacks and compares every architectural writeback from the core against the queue head. It also detects program end via `pc_out` and sequences drain, `dump` and final verdict; it runs beside `riscv_pipeline` in bench top-levels.

---
 rtl/riscv_tb_pkg.sv | 22 ++
 rtl/wb_exp_fifo.sv | 60 ++++++
 rtl/riscv_wb_scoreboard.sv | 158 +++++++++++++++
 tb/tb_riscv_wb_scoreboard.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_tb_pkg.sv
// Shared types and defaults for the writeback scoreboard used next to riscv_pipeline.
package riscv_tb_pkg;

    localparam int WB_XLEN          = 32;
    localparam int WB_REG_AW        = 5;
    localparam int PC_END_DEF       = 52;
    localparam int DRAIN_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        SB_IDLE,
        SB_RUN,
        SB_DRAIN,
        SB_DUMP,
        SB_DONE
    } sb_state_t;

    typedef struct packed {
        logic [WB_REG_AW-1:0] addr;
        logic [WB_XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_exp_fifo.sv
// Synchronous FIFO of expected writebacks; push and pop in one cycle keep occupancy.
module wb_exp_fifo
    import riscv_tb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    wb_entry_t        mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_wb_scoreboard.sv
// Writeback scoreboard: checks core writebacks against an ordered expected queue,
// detects program end from pc_out and sequences drain, dump and the final verdict.
module riscv_wb_scoreboard
    import riscv_tb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int DEPTH        = 16,
    parameter int PC_END       = PC_END_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int TIMEOUT      = 1024,
    parameter int CW           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [REG_AW-1:0] exp_addr,
    input  logic [XLEN-1:0]   exp_data,
    input  logic              wb_e,
    input  logic [REG_AW-1:0] wb_a,
    input  logic [XLEN-1:0]   wb_d,
    input  logic [XLEN-1:0]   pc_out,
    output logic              dump,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CW-1:0]     match_cnt,
    output logic [CW-1:0]     fail_cnt,
    output logic              err_valid,
    output logic [REG_AW-1:0] err_addr,
    output logic [XLEN-1:0]   err_exp,
    output logic [XLEN-1:0]   err_act,
    output sb_state_t         dbg_state
);

    localparam int RCW = $clog2(TIMEOUT + 1);
    localparam int DCW = $clog2(DRAIN_CYCLES + 2);

    sb_state_t      state;
    sb_state_t      state_nxt;
    logic           timeout_hit;
    logic [RCW-1:0] run_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           ready_en;
    logic           cmp_active;
    logic           wb_hit;
    logic           pop;
    logic           push;
    logic           end_hit;
    logic           run_last;
    logic           drain_last;
    logic           fifo_full;
    logic           fifo_empty;
    logic           head_match;
    wb_entry_t      head;
    wb_entry_t      push_entry;

    assign dbg_state  = state;
    assign cmp_active = (state == SB_RUN) || (state == SB_DRAIN);
    assign wb_hit     = cmp_active && wb_e && (wb_a != '0);
    assign pop        = wb_hit && !fifo_empty;
    // Handshake: an entry transfers on a rising clk edge where exp_valid && exp_ready;
    // exp_ready may depend on this cycle's writeback, since a pop frees the slot.
    assign exp_ready  = ready_en && (!fifo_full || pop);
    assign push       = exp_valid && exp_ready;
    assign push_entry = '{addr: exp_addr, data: exp_data};
    assign head_match = (head.addr == wb_a) && (head.data == wb_d);
    assign end_hit    = (pc_out >= XLEN'(PC_END));
    assign run_last   = (int'(run_cnt) + 1 >= TIMEOUT);
    assign drain_last = (int'(drain_cnt) + 1 >= DRAIN_CYCLES);

    wb_exp_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            SB_IDLE:  if (start) state_nxt = SB_RUN;
            SB_RUN: begin
                // End of program wins over a timeout landing in the same cycle.
                if (end_hit) begin
                    state_nxt = SB_DRAIN;
                end else if (run_last) begin
                    state_nxt   = SB_DONE;
                    timeout_hit = 1'b1;
                end
            end
            SB_DRAIN: if (drain_last) state_nxt = SB_DUMP;
            SB_DUMP:  state_nxt = SB_DONE;
            SB_DONE:  state_nxt = SB_DONE;
            default:  state_nxt = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SB_IDLE;
            run_cnt   <= '0;
            drain_cnt <= '0;
            ready_en  <= 1'b0;
            dump      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_cnt   <= (state == SB_RUN) ? run_cnt + 1'b1 : '0;
            drain_cnt <= (state == SB_DRAIN) ? drain_cnt + 1'b1 : '0;
            ready_en  <= (state_nxt != SB_DONE);
            dump      <= (state_nxt == SB_DUMP);
            done      <= (state_nxt == SB_DONE);
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
            if (state == SB_DUMP) begin
                pass <= (fail_cnt == '0) && fifo_empty && !timeout;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
            fail_cnt  <= '0;
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_exp   <= '0;
            err_act   <= '0;
        end else if (wb_hit) begin
            if (!fifo_empty && head_match) begin
                if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
            end else begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                // Only the first failure since reset is kept for diagnosis.
                if (!err_valid) begin
                    err_valid <= 1'b1;
                    err_addr  <= wb_a;
                    err_exp   <= fifo_empty ? '0 : head.data;
                    err_act   <= wb_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// Directed bench for riscv_wb_scoreboard: verdicts are queued per run and checked on done.
module tb_riscv_wb_scoreboard;
    import riscv_tb_pkg::*;

    localparam int W       = 108;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_ready;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic        wb_e = 1'b0;
    logic [4:0]  wb_a = '0;
    logic [31:0] wb_d = '0;
    logic [31:0] pc_out = '0;
    logic        dump, done, pass, timeout, err_valid;
    logic [15:0] match_cnt, fail_cnt;
    logic [4:0]  err_addr;
    logic [31:0] err_exp, err_act;
    sb_state_t   dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];
    logic       done_seen = 1'b0;
    logic [3:0] dump_n = '0;

    riscv_wb_scoreboard #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_addr(exp_addr), .exp_data(exp_data),
        .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d), .pc_out(pc_out),
        .dump(dump), .done(done), .pass(pass), .timeout(timeout),
        .match_cnt(match_cnt), .fail_cnt(fail_cnt),
        .err_valid(err_valid), .err_addr(err_addr), .err_exp(err_exp), .err_act(err_act),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] pack_v(input logic p, input logic t, input logic ev,
                                           input logic [4:0] ea, input logic [31:0] ee,
                                           input logic [31:0] eact, input logic [15:0] mc,
                                           input logic [15:0] fc, input logic [3:0] dn);
        return {p, t, ev, ea, ee, eact, mc, fc, dn};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: one verdict per run, compared when done first rises
    always @(negedge clk) begin
        if (reset) begin
            done_seen = 1'b0;
            dump_n = '0;
        end else begin
            if (dump) dump_n = dump_n + 1'b1;
            if (done && !done_seen) begin
                done_seen = 1'b1;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL verdict_unexpected: got done with no expected verdict queued");
                end else begin
                    logic [W-1:0] e;
                    logic [W-1:0] a;
                    e = exp_q.pop_front();
                    a = pack_v(pass, timeout, err_valid, err_addr, err_exp, err_act,
                               match_cnt, fail_cnt, dump_n);
                    if (a !== e) begin
                        tests_failed++;
                        $display("FAIL verdict: got %h expected %h", a, e);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; exp_valid = 1'b0; wb_e = 1'b0; wb_a = '0; wb_d = '0; pc_out = '0;
        #1;
        check("rst_dump", 32'(dump), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_err_addr", 32'(err_addr), 32'd0);
        check("rst_err_exp", err_exp, 32'd0);
        check("rst_err_act", err_act, 32'd0);
        check("rst_match_cnt", 32'(match_cnt), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        check("rst_exp_ready", 32'(exp_ready), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(SB_IDLE));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d, output logic rdy);
        exp_valid = 1'b1; exp_addr = a; exp_data = d;
        @(negedge clk);
        rdy = exp_ready;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_e = 1'b1; wb_a = a; wb_d = d;
        tick();
        wb_e = 1'b0; wb_a = '0; wb_d = '0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s: done not seen within %0d cycles, got 0 expected 1", name, budget);
        end
        tick();
    endtask

    task automatic end_run(input string name);
        pc_out = 32'd52;
        wait_done(40, name);
        pc_out = '0;
    endtask

    task automatic load_four(input logic [31:0] last_ok);
        logic rdy;
        push_exp(5'd1, 32'hDEADBEEF, rdy); check("load_rdy1", 32'(rdy), 32'd1);
        push_exp(5'd2, 32'h12345678, rdy); check("load_rdy2", 32'(rdy), 32'd1);
        push_exp(5'd7, 32'h00000004, rdy); check("load_rdy3", 32'(rdy), 32'd1);
        push_exp(5'd3, last_ok, rdy);      check("load_rdy4", 32'(rdy), 32'd1);
    endtask

    initial begin
        logic rdy;
        int   lat;

        // 1: four matching writebacks, dump latency and width
        do_reset();
        load_four(32'hFEDCBA98);
        exp_q.push_back(pack_v(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 16'd4, 16'd0, 4'd1));
        start_run();
        wb(5'd1, 32'hDEADBEEF);
        wb(5'd2, 32'h12345678);
        wb(5'd7, 32'h00000004);
        wb(5'd3, 32'hFEDCBA98);
        pc_out = 32'd52;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (dump) break;
        end
        check("dump_latency", 32'(lat), 32'd5);
        tick();
        check("dump_width", 32'(dump), 32'd0);
        wait_done(10, "t1_done");
        pc_out = '0;

        // 2: data mismatch on the fourth writeback
        do_reset();
        load_four(32'hFEDCBA98);
        exp_q.push_back(pack_v(1'b0, 1'b0, 1'b1, 5'd3, 32'hFEDCBA98, 32'hFEDCBA99,
                               16'd3, 16'd1, 4'd1));
        start_run();
        wb(5'd1, 32'hDEADBEEF);
        wb(5'd2, 32'h12345678);
        wb(5'd7, 32'h00000004);
        wb(5'd3, 32'hFEDCBA99);
        end_run("t2_done");

        // 3: x0 write ignored, unexpected write on empty queue
        do_reset();
        push_exp(5'd1, 32'hDEADBEEF, rdy);
        check("t3_rdy", 32'(rdy), 32'd1);
        exp_q.push_back(pack_v(1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'd1, 16'd1, 16'd1, 4'd1));
        start_run();
        wb(5'd0, 32'd5);
        wb(5'd1, 32'hDEADBEEF);
        wb(5'd5, 32'd1);
        end_run("t3_done");

        // 4: full queue, push accepted only alongside a pop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_exp(5'(i + 1), 32'h100 + 32'(i), rdy);
            check("fill_rdy", 32'(rdy), 32'd1);
        end
        exp_q.push_back(pack_v(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 16'd17, 16'd0, 4'd1));
        start_run();
        exp_valid = 1'b1; exp_addr = 5'd17; exp_data = 32'h200;
        wb_e = 1'b1; wb_a = 5'd1; wb_d = 32'h100;
        @(negedge clk);
        check("full_push_pop_rdy", 32'(exp_ready), 32'd1);
        tick();
        wb_e = 1'b0; wb_a = '0; wb_d = '0;
        exp_addr = 5'd18; exp_data = 32'h300;
        @(negedge clk);
        check("full_push_rdy", 32'(exp_ready), 32'd0);
        tick();
        exp_valid = 1'b0;
        for (int i = 1; i < 16; i++) wb(5'(i + 1), 32'h100 + 32'(i));
        wb(5'd17, 32'h200);
        end_run("t4_done");

        // 5: timeout with pc stuck below the end address
        do_reset();
        exp_q.push_back(pack_v(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 16'd0, 16'd0, 4'd0));
        start_run();
        pc_out = 32'd8;
        repeat (1000) tick();
        check("t5_not_done_early", 32'(done), 32'd0);
        check("t5_still_run", 32'(dbg_state), 32'(SB_RUN));
        wait_done(100, "t5_done");
        pc_out = '0;

        // 6: reset in DRAIN clears queue; fresh run passes
        do_reset();
        push_exp(5'd1, 32'hDEADBEEF, rdy);
        push_exp(5'd2, 32'h5, rdy);
        start_run();
        wb(5'd1, 32'hDEADBEEF);
        pc_out = 32'd52;
        tick();
        tick();
        #2;
        check("t6_in_drain", 32'(dbg_state), 32'(SB_DRAIN));
        do_reset();
        push_exp(5'd1, 32'hDEADBEEF, rdy);
        check("t6_rdy", 32'(rdy), 32'd1);
        exp_q.push_back(pack_v(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 16'd1, 16'd0, 4'd1));
        start_run();
        wb(5'd1, 32'hDEADBEEF);
        end_run("t6_done");

        check("verdicts_left", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
